// File: rtl/apb_bus_master_if.sv
// APB bus bundle between the CPU bridge and its five peripheral slaves.
// The master drives address, data, strobes and selects; slaves return data and ready.
interface apb_bus_master_if;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic [3:0]  PSTRB;
    logic        PENABLE;
    logic        PSEL0;
    logic        PSEL1;
    logic        PSEL2;
    logic        PSEL3;
    logic        PSEL4;
    logic [31:0] PRDATA0;
    logic [31:0] PRDATA1;
    logic [31:0] PRDATA2;
    logic [31:0] PRDATA3;
    logic [31:0] PRDATA4;
    logic        PREADY0;
    logic        PREADY1;
    logic        PREADY2;
    logic        PREADY3;
    logic        PREADY4;

    modport master (
        output PADDR, PWDATA, PWRITE, PSTRB, PENABLE,
        output PSEL0, PSEL1, PSEL2, PSEL3, PSEL4,
        input  PRDATA0, PRDATA1, PRDATA2, PRDATA3, PRDATA4,
        input  PREADY0, PREADY1, PREADY2, PREADY3, PREADY4
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSTRB, PENABLE,
        input  PSEL0, PSEL1, PSEL2, PSEL3, PSEL4,
        output PRDATA0, PRDATA1, PRDATA2, PRDATA3, PRDATA4,
        output PREADY0, PREADY1, PREADY2, PREADY3, PREADY4
    );
endinterface

// File: rtl/apb_bus_master.sv
// Bridge from the RV32I core data port to APB: one request at a time, five decoded slaves,
// wait states with a bounded timeout, and a single-cycle ready/err completion pulse.
module apb_bus_master #(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             transfer,
    input  logic             write,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [2:0]       strb,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic             err,
    apb_bus_master_if.master apb
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERROR} state_t;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] wait_cnt;
    logic [2:0]  sel_idx;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic        pwrite_q;
    logic [3:0]  pstrb_q;

    logic [2:0]  dec_idx;
    logic        dec_hit;
    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        timed_out;
    logic        bus_active;

    always_comb begin
        dec_hit = 1'b1;
        dec_idx = 3'd0;
        case (addr[31:12])
            20'h10000: dec_idx = 3'd0;
            20'h10001: dec_idx = 3'd1;
            20'h10002: dec_idx = 3'd2;
            20'h10003: dec_idx = 3'd3;
            20'h10004: dec_idx = 3'd4;
            default:   dec_hit = 1'b0;
        endcase
    end

    // funct3 bit 2 only distinguishes signed/unsigned loads, so it never affects the lanes
    always_comb begin
        lane_strb  = 4'b1111;
        lane_wdata = wdata;
        casez (strb)
            3'b?00: begin
                lane_strb  = 4'b0001 << addr[1:0];
                lane_wdata = {4{wdata[7:0]}};
            end
            3'b?01: begin
                lane_strb  = 4'b0011 << {addr[1], 1'b0};
                lane_wdata = {2{wdata[15:0]}};
            end
            default: begin
                lane_strb  = 4'b1111;
                lane_wdata = wdata;
            end
        endcase
        if (!write) begin
            lane_strb = 4'b0000;
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = 32'd0;
        case (sel_idx)
            3'd0: begin sel_ready = apb.PREADY0; sel_rdata = apb.PRDATA0; end
            3'd1: begin sel_ready = apb.PREADY1; sel_rdata = apb.PRDATA1; end
            3'd2: begin sel_ready = apb.PREADY2; sel_rdata = apb.PRDATA2; end
            3'd3: begin sel_ready = apb.PREADY3; sel_rdata = apb.PRDATA3; end
            3'd4: begin sel_ready = apb.PREADY4; sel_rdata = apb.PRDATA4; end
            default: begin sel_ready = 1'b0; sel_rdata = 32'd0; end
        endcase
    end

    assign timed_out = (wait_cnt == LAST_WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        err        = 1'b0;
        rdata      = 32'd0;
        case (state)
            IDLE: begin
                if (transfer) begin
                    state_next = dec_hit ? SETUP : ERROR;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    ready      = 1'b1;
                    rdata      = sel_rdata;
                    state_next = IDLE;
                end else if (timed_out) begin
                    ready      = 1'b1;
                    err        = 1'b1;
                    state_next = IDLE;
                end
            end
            ERROR: begin
                ready      = 1'b1;
                err        = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // SETUP always precedes ACCESS, so clearing there gives a fresh count on ACCESS entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 16'd0;
        end else if (state == SETUP) begin
            wait_cnt <= 16'd0;
        end else if (state == ACCESS && !sel_ready) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            paddr_q  <= 32'd0;
            pwdata_q <= 32'd0;
            pwrite_q <= 1'b0;
            pstrb_q  <= 4'd0;
            sel_idx  <= 3'd0;
        end else if (state == IDLE && transfer) begin
            paddr_q  <= addr;
            pwdata_q <= lane_wdata;
            pwrite_q <= write;
            pstrb_q  <= lane_strb;
            sel_idx  <= dec_idx;
        end
    end

    assign bus_active  = (state == SETUP) || (state == ACCESS);
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PSTRB   = pstrb_q;
    assign apb.PENABLE = (state == ACCESS);
    assign apb.PSEL0   = bus_active && (sel_idx == 3'd0);
    assign apb.PSEL1   = bus_active && (sel_idx == 3'd1);
    assign apb.PSEL2   = bus_active && (sel_idx == 3'd2);
    assign apb.PSEL3   = bus_active && (sel_idx == 3'd3);
    assign apb.PSEL4   = bus_active && (sel_idx == 3'd4);

endmodule

// File: tb/tb_apb_bus_master.sv
// Randomized bench for apb_bus_master: a transaction-level model predicts every cycle
// of each request, and directed cases pin the model with hand-derived literal values.
module tb_apb_bus_master;

    localparam int TMO = 4;

    logic        clk;
    logic        reset;
    logic        transfer;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  strb;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    logic [31:0] prd [5];
    logic        prdy [5];

    int checks;
    int errors;

    logic        chk_en;
    logic [4:0]  e_psel;
    logic        e_pen;
    logic        e_ready;
    logic        e_err;
    logic [31:0] e_rdata;
    logic        e_bus;
    logic [31:0] e_paddr;
    logic        e_pwrite;
    logic [3:0]  e_pstrb;
    logic [31:0] e_pwdata;
    logic        e_wchk;

    apb_bus_master_if apb();

    assign apb.PRDATA0 = prd[0];
    assign apb.PRDATA1 = prd[1];
    assign apb.PRDATA2 = prd[2];
    assign apb.PRDATA3 = prd[3];
    assign apb.PRDATA4 = prd[4];
    assign apb.PREADY0 = prdy[0];
    assign apb.PREADY1 = prdy[1];
    assign apb.PREADY2 = prdy[2];
    assign apb.PREADY3 = prdy[3];
    assign apb.PREADY4 = prdy[4];

    wire [4:0] psel = {apb.PSEL4, apb.PSEL3, apb.PSEL2, apb.PSEL1, apb.PSEL0};

    apb_bus_master #(.TIMEOUT(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .strb     (strb),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .apb      (apb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every active cycle is compared against the model's prediction for that cycle
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("psel", 32'(psel), 32'(e_psel));
            checkOutput("penable", 32'(apb.PENABLE), 32'(e_pen));
            checkOutput("ready", 32'(ready), 32'(e_ready));
            checkOutput("err", 32'(err), 32'(e_err));
            if (e_ready) checkOutput("rdata", rdata, e_rdata);
            if (e_bus) begin
                checkOutput("paddr", apb.PADDR, e_paddr);
                checkOutput("pwrite", 32'(apb.PWRITE), 32'(e_pwrite));
                checkOutput("pstrb", 32'(apb.PSTRB), 32'(e_pstrb));
                if (e_wchk) checkOutput("pwdata", apb.PWDATA, e_pwdata);
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_psel"}, 32'(psel), 32'd0);
        checkOutput({tag, "_penable"}, 32'(apb.PENABLE), 32'd0);
        checkOutput({tag, "_ready"}, 32'(ready), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_rdata"}, rdata, 32'd0);
        checkOutput({tag, "_paddr"}, apb.PADDR, 32'd0);
        checkOutput({tag, "_pwdata"}, apb.PWDATA, 32'd0);
        checkOutput({tag, "_pwrite"}, 32'(apb.PWRITE), 32'd0);
        checkOutput({tag, "_pstrb"}, 32'(apb.PSTRB), 32'd0);
    endtask

    task automatic randomInputs();
        transfer = 1'($urandom_range(0, 1));
        write    = 1'($urandom_range(0, 1));
        addr     = $urandom;
        wdata    = $urandom;
        strb     = 3'($urandom_range(0, 7));
        for (int i = 0; i < 5; i++) begin
            prd[i]  = $urandom;
            prdy[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic setIdleExpect();
        e_psel  = 5'd0;
        e_pen   = 1'b0;
        e_ready = 1'b0;
        e_err   = 1'b0;
        e_rdata = 32'd0;
        e_bus   = 1'b0;
        e_wchk  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            randomInputs();
            transfer = 1'b0;
            setIdleExpect();
            chk_en = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    // One request: phase 0 is the request cycle, phase 1 SETUP/ERROR, phase 2+k the k-th ACCESS
    task automatic applyStimulus(input logic [31:0] a, input logic we, input logic [31:0] wd,
                                 input logic [2:0] st, input int waits, input logic [31:0] prdsel,
                                 output int lat, output logic [3:0] cStrb, output logic [31:0] cWdata,
                                 output logic [31:0] cRdata, output logic cErr, output int pselCycles);
        logic        mapped;
        logic        tmo;
        int          idx;
        int          last;
        logic [3:0]  xs;
        logic [31:0] xw;
        mapped = (a[31:12] >= 20'h10000) && (a[31:12] <= 20'h10004);
        idx    = mapped ? int'(a[31:12] - 20'h10000) : 0;
        case (st[1:0])
            2'd0: begin
                xs = 4'(1 << a[1:0]);
                xw = {24'h0, wd[7:0]} * 32'h01010101;
            end
            2'd1: begin
                xs = 4'(3 << (a[1:0] & 2'b10));
                xw = {16'h0, wd[15:0]} * 32'h00010001;
            end
            default: begin
                xs = 4'hF;
                xw = wd;
            end
        endcase
        if (!we) xs = 4'h0;
        tmo  = waits > (TMO - 1);
        last = mapped ? 2 + (tmo ? TMO - 1 : waits) : 1;
        lat = -1; pselCycles = 0; cStrb = 4'h0; cWdata = 32'h0; cRdata = 32'h0; cErr = 1'b0;
        for (int ph = 0; ph <= last; ph++) begin
            randomInputs();
            if (ph == 0) begin
                transfer = 1'b1; addr = a; write = we; wdata = wd; strb = st;
            end else if (ph == last) begin
                transfer = 1'b1; addr = 32'h1000_0000;
            end
            if (mapped && ph >= 2) begin
                prd[idx]  = prdsel;
                prdy[idx] = (ph - 2 == waits);
            end
            e_psel   = (mapped && ph >= 1) ? 5'(1 << idx) : 5'd0;
            e_pen    = mapped && ph >= 2;
            e_ready  = (ph == last);
            e_err    = e_ready && (!mapped || tmo);
            e_rdata  = (e_ready && mapped && !tmo) ? prdsel : 32'd0;
            e_bus    = mapped && ph >= 1;
            e_paddr  = a;
            e_pwrite = we;
            e_pstrb  = xs;
            e_pwdata = xw;
            e_wchk   = we;
            chk_en   = 1'b1;
            @(negedge clk);
            if (ready && lat < 0) begin
                lat = ph; cRdata = rdata; cErr = err;
            end
            if (psel != 5'd0) pselCycles++;
            if (ph == 1) begin
                cStrb = apb.PSTRB; cWdata = apb.PWDATA;
            end
            @(posedge clk);
            #1;
        end
        idleCycles(1);
    endtask

    initial begin
        int          lat;
        int          pc;
        logic [3:0]  cs;
        logic [31:0] cw;
        logic [31:0] cr;
        logic        ce;
        logic [31:0] ra;
        logic [2:0]  rs;

        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        setIdleExpect();
        e_paddr = 32'd0; e_pwrite = 1'b0; e_pstrb = 4'd0; e_pwdata = 32'd0;
        reset = 1'b0;
        randomInputs();

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            randomInputs();
            @(negedge clk);
            checkAllZero("reset");
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        idleCycles(3);

        $display("[TB] directed transfers");
        applyStimulus(32'h1000_1000, 1'b1, 32'hDEADBEEF, 3'b010, 0, 32'h0, lat, cs, cw, cr, ce, pc);
        checkOutput("word_lat", 32'(lat), 32'd2);
        checkOutput("word_pstrb", 32'(cs), 32'hF);
        checkOutput("word_pwdata", cw, 32'hDEADBEEF);
        checkOutput("word_err", 32'(ce), 32'd0);
        checkOutput("word_psel_cycles", 32'(pc), 32'd2);

        applyStimulus(32'h1000_0003, 1'b1, 32'h0000_00A5, 3'b000, 1, 32'h0, lat, cs, cw, cr, ce, pc);
        checkOutput("byte_pstrb", 32'(cs), 32'h8);
        checkOutput("byte_pwdata", cw, 32'hA5A5A5A5);

        applyStimulus(32'h1000_0002, 1'b1, 32'h0000_1234, 3'b001, 0, 32'h0, lat, cs, cw, cr, ce, pc);
        checkOutput("half_pstrb", 32'(cs), 32'hC);
        checkOutput("half_pwdata", cw, 32'h12341234);

        applyStimulus(32'h1000_2000, 1'b0, 32'h0, 3'b010, 3, 32'h0000_00FF, lat, cs, cw, cr, ce, pc);
        checkOutput("load_lat", 32'(lat), 32'd5);
        checkOutput("load_rdata", cr, 32'h0000_00FF);
        checkOutput("load_pstrb", 32'(cs), 32'h0);
        checkOutput("load_err", 32'(ce), 32'd0);

        applyStimulus(32'h2000_0000, 1'b0, 32'h0, 3'b010, 0, 32'h0, lat, cs, cw, cr, ce, pc);
        checkOutput("unmapped_lat", 32'(lat), 32'd1);
        checkOutput("unmapped_err", 32'(ce), 32'd1);
        checkOutput("unmapped_rdata", cr, 32'd0);
        checkOutput("unmapped_psel_cycles", 32'(pc), 32'd0);

        applyStimulus(32'h1000_5000, 1'b1, 32'h1, 3'b010, 0, 32'h0, lat, cs, cw, cr, ce, pc);
        checkOutput("above_map_err", 32'(ce), 32'd1);

        applyStimulus(32'h1000_4000, 1'b0, 32'h0, 3'b010, 100, 32'h5555_AAAA, lat, cs, cw, cr, ce, pc);
        checkOutput("timeout_lat", 32'(lat), 32'd5);
        checkOutput("timeout_err", 32'(ce), 32'd1);
        checkOutput("timeout_rdata", cr, 32'd0);
        checkOutput("timeout_psel_cycles", 32'(pc), 32'd5);

        $display("[TB] random transfers");
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) != 0)
                ra = {20'h10000 + 20'($urandom_range(0, 4)), 12'($urandom)};
            else
                ra = $urandom;
            rs = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
            applyStimulus(ra, 1'($urandom_range(0, 1)), $urandom, rs, $urandom_range(0, 5),
                          $urandom, lat, cs, cw, cr, ce, pc);
            idleCycles($urandom_range(0, 2));
        end

        $display("[TB] reset during stalled transfer");
        chk_en = 1'b0;
        randomInputs();
        for (int i = 0; i < 5; i++) prdy[i] = 1'b0;
        transfer = 1'b1; addr = 32'h1000_4010; write = 1'b0; strb = 3'b010;
        @(posedge clk);
        #1;
        transfer = 1'b0;
        @(negedge clk);
        checkOutput("stall_setup_psel", 32'(psel), 32'h10);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("stall_access_penable", 32'(apb.PENABLE), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkAllZero("midreset");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("midreset_ready", 32'(ready), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        idleCycles(3);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/apb_bus_master.md
# apb_bus_master

Bridge between the multi-cycle RV32I core's data-bus port and the AMBA APB peripheral bus, sitting directly downstream of the control unit and datapath. It accepts one CPU load/store request at a time and decodes the address to one of five slave selects. It runs an APB3/APB4 SETUP→ACCESS transfer with wait-state and timeout support, then returns read data plus a one-cycle `ready` so the core can leave its MEM state. Byte lanes come from the store-width code (`strb` = funct3).

## Interface
Parameters:
- `TIMEOUT`, 255: maximum ACCESS cycles waiting for PREADY before forced error completion (1..65535).

Ports:
- `clk`  in  1  system clock, all flops rising-edge.
- `reset`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `transfer`  in  1  request strobe from core; sampled only in IDLE.
- `write`  in  1  1 = store (busWe), 0 = load.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data, value in low bits.
- `strb`  in  3  funct3 width code: x00 byte, x01 half, x10 word.
- `rdata`  out  32  read data, valid while `ready`=1.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `ready`: unmapped address or timeout.
- `PADDR`  out  32  latched address.
- `PWDATA`  out  32  lane-replicated write data.
- `PWRITE`  out  1  latched direction.
- `PSTRB`  out  4  byte-lane strobes.
- `PENABLE`  out  1  APB enable.
- `PSEL0..PSEL4`  out  1 each  slave selects.
- `PRDATA0..PRDATA4`  in  32 each  slave read data.
- `PREADY0..PREADY4`  in  1 each  slave ready.

## Operation
- Address map, decoded on `addr[31:12]`:
  - 0x10000 → PSEL0 (RAM)
  - 0x10001 → PSEL1 (GPO)
  - 0x10002 → PSEL2 (GPI)
  - 0x10003 → PSEL3 (GPIO)
  - 0x10004 → PSEL4 (UART)
  - Anything else is unmapped.
- FSM states IDLE, SETUP, ACCESS, ERROR.
  - IDLE: when `transfer`=1, latch addr/wdata/write/strb/decoded select. Go to SETUP if mapped, otherwise ERROR.
  - SETUP: selected PSELx=1, PENABLE=0. Always go to ACCESS next cycle.
  - ACCESS: PSELx=1, PENABLE=1.
    - Selected PREADYx=1: `ready`=1, `rdata`=selected PRDATAx (combinational pass-through), `err`=0, go to IDLE.
    - Wait counter reaches TIMEOUT−1 with PREADY still 0: `ready`=1, `err`=1, `rdata`=0, go to IDLE.
  - ERROR: `ready`=1, `err`=1, `rdata`=0, no PSEL asserted, go to IDLE.
- `transfer` in any state other than IDLE is ignored. No queuing.
- PSTRB:
  - Reads: 4'b0000.
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << {addr[1],1'b0}.
  - Word: 4'b1111.
- PWDATA:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Unselected PRDATA/PREADY are ignored. Non-selected PSELx stay 0 at all times.
- Wait counter is 16 bits, cleared on entry to ACCESS, incremented each ACCESS cycle with PREADY=0.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, all PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, ready=0, err=0, rdata=0, counter=0.
- Reset asserted mid-transfer aborts immediately. No `ready` is generated.
- Zero-wait mapped transfer, with `transfer` sampled at edge N:
  - SETUP in cycle N+1.
  - ACCESS with `ready`=1 in cycle N+2.
  - IDLE in cycle N+3.
  - Latency from request to `ready` is 2 cycles, plus k wait cycles.
- Unmapped address: ERROR in cycle N+1 with `ready`=1. Latency is 1 cycle.
- Timeout: `ready`/`err` rise in the TIMEOUT-th ACCESS cycle.
- PADDR/PWRITE/PWDATA/PSTRB stay stable from SETUP through the last ACCESS cycle, per the APB rule.
- `ready` is never high for more than one consecutive cycle.
- A new `transfer` asserted in the same cycle as `ready` is ignored. The next request is accepted no earlier than the following IDLE cycle.

## Test plan
- Reset: hold reset=0 with random inputs → all outputs 0. Release → state IDLE; PSEL0..4 stay 0 without `transfer`.
- Word store: addr=0x1000_1000, wdata=0xDEADBEEF, strb=010, write=1, PREADY1=1 → PSEL1 high 2 cycles (PENABLE only in 2nd), PSTRB=1111, PWDATA=0xDEADBEEF, `ready`=1 at N+2, err=0.
- Byte store: addr=0x1000_0003, wdata=0x000000A5, strb=000 → PSTRB=1000, PWDATA=0xA5A5A5A5. Half store at addr=0x1000_0002, wdata=0x1234 → PSTRB=1100, PWDATA=0x12341234.
- Load with waits: addr=0x1000_2000, write=0, PREADY2 low 3 ACCESS cycles then high, PRDATA2=0x0000_00FF → `ready` at N+5, rdata=0x0000_00FF, PSTRB=0000, err=0.
- Unmapped: addr=0x2000_0000 → no PSEL asserted, `ready`=1 and err=1 at N+1, rdata=0.
- Timeout with TIMEOUT=4: access PSEL4, PREADY4 held 0 → `ready`=1, err=1 in 4th ACCESS cycle. Then IDLE. A reset pulse during a second stalled transfer returns all outputs to 0 with no `ready`.
